recload_sequencer: RTL and testbench

- Receive-side load controller that sequences the 16-bit receive registers: ID word, control word and four data words.
- Takes the destuffed byte stream from the MAC receive shift path and packs bytes into hi/lo pairs.
- Issues one-cycle load strobes (the registers' `can` inputs) with the matching `regin1`/`regin2` values.
- Reports frame completion or error to the MAC/interrupt logic.

---
 rtl/recload_if.sv | 27 ++
 rtl/recload_sequencer.sv | 130 +++++++++++++
 tb/tb_recload_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/recload_if.sv
// Receive-load bus between the MAC receive path and recload_sequencer.
// master drives the byte stream and frame strobes; slave drives the register loads and status.
interface recload_if #(
    parameter int unsigned NREG = 6
);
    logic            sof;
    logic            byte_valid;
    logic [7:0]      byte_in;
    logic            eof;
    logic            abort;
    logic [NREG-1:0] reg_load;
    logic [7:0]      regin1;
    logic [7:0]      regin2;
    logic            rec_busy;
    logic            rec_done;
    logic            rec_err;

    modport master (
        output sof, byte_valid, byte_in, eof, abort,
        input  reg_load, regin1, regin2, rec_busy, rec_done, rec_err
    );

    modport slave (
        input  sof, byte_valid, byte_in, eof, abort,
        output reg_load, regin1, regin2, rec_busy, rec_done, rec_err
    );
endinterface

// File: rtl/recload_sequencer.sv
// Packs the destuffed receive byte stream into hi/lo pairs and strobes the ID/control/data registers.
// Optional RECLOAD_CLEAR_EN: clears all receive registers in the cycle after an accepted sof.
module recload_sequencer #(
    parameter int unsigned NREG   = 6,
    parameter int unsigned MAXDLC = 8
) (
    input  logic     clk,
    input  logic     rst,
    recload_if.slave bus
);
    localparam int unsigned IW        = $clog2(NREG);
    localparam int unsigned CW        = $clog2(MAXDLC + 1);
    localparam int unsigned DATA_BASE = 2;

    typedef enum logic [1:0] {IDLE, HI, LO, WAIT_EOF} state_t;

    state_t          state, state_d;
    logic [7:0]      hold, hold_d;
    logic [IW-1:0]   idx, idx_d;
    logic [CW-1:0]   rem, rem_d;
    logic [CW-1:0]   dlc_clamped;
    logic [NREG-1:0] load_d;
    logic [7:0]      r1_d, r2_d;
    logic            busy_d, done_d, err_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hold         <= '0;
            idx          <= '0;
            rem          <= '0;
            bus.reg_load <= '0;
            bus.regin1   <= '0;
            bus.regin2   <= '0;
            bus.rec_busy <= 1'b0;
            bus.rec_done <= 1'b0;
            bus.rec_err  <= 1'b0;
        end else begin
            state        <= state_d;
            hold         <= hold_d;
            idx          <= idx_d;
            rem          <= rem_d;
            bus.reg_load <= load_d;
            bus.regin1   <= r1_d;
            bus.regin2   <= r2_d;
            bus.rec_busy <= busy_d;
            bus.rec_done <= done_d;
            bus.rec_err  <= err_d;
        end
    end

    // Next state and next outputs; priority abort > sof > eof > byte
    always_comb begin
        state_d = state;
        hold_d  = hold;
        idx_d   = idx;
        rem_d   = rem;
        load_d  = '0;
        r1_d    = '0;
        r2_d    = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        dlc_clamped = (32'(hold[3:0]) > MAXDLC) ? CW'(MAXDLC) : CW'(hold[3:0]);

        if (state != IDLE && bus.abort) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else if (bus.sof && !bus.abort) begin
            err_d   = (state != IDLE);
            state_d = HI;
            idx_d   = '0;
            rem_d   = '0;
            hold_d  = '0;
`ifdef RECLOAD_CLEAR_EN
            load_d  = '1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                end
                HI: begin
                    if (bus.eof) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else if (bus.byte_valid) begin
                        // last byte of an odd-length data field goes out zero-padded
                        if (idx >= IW'(DATA_BASE) && rem == CW'(1)) begin
                            load_d  = NREG'(1) << idx;
                            r1_d    = bus.byte_in;
                            rem_d   = '0;
                            state_d = WAIT_EOF;
                        end else begin
                            hold_d  = bus.byte_in;
                            state_d = LO;
                        end
                    end
                end
                LO: begin
                    if (bus.eof) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else if (bus.byte_valid) begin
                        load_d  = NREG'(1) << idx;
                        r1_d    = hold;
                        r2_d    = bus.byte_in;
                        idx_d   = idx + IW'(1);
                        state_d = HI;
                        if (idx == IW'(1)) begin
                            // hold carries the control byte with the DLC
                            rem_d = dlc_clamped;
                            if (dlc_clamped == '0) state_d = WAIT_EOF;
                        end else if (idx >= IW'(DATA_BASE)) begin
                            rem_d = rem - CW'(2);
                            if (rem == CW'(2)) state_d = WAIT_EOF;
                        end
                    end
                end
                WAIT_EOF: begin
                    if (bus.eof) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end
endmodule

// File: tb/tb_recload_sequencer.sv
// Bench for recload_sequencer: directed frames plus random frames against a byte-position model.
module tb_recload_sequencer;
    localparam int unsigned NREG   = 6;
    localparam int unsigned MAXDLC = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    recload_if #(.NREG(NREG)) bus ();

    recload_sequencer #(.NREG(NREG), .MAXDLC(MAXDLC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Frame model: bytes accepted so far in the current frame
    logic [7:0]      fb [0:15];
    int              m_cnt;
    int              m_n;
    bit              m_active;
    logic [NREG-1:0] exp_load;
    logic [7:0]      exp_r1, exp_r2;
    logic            exp_done, exp_err;
    logic [7:0]      fq [$];

    function automatic bit frame_complete();
        return (m_cnt >= 4) && ((m_cnt - 4) >= m_n);
    endfunction

    task automatic expect_load(input int r, input logic [7:0] h, input logic [7:0] l);
        exp_load    = '0;
        exp_load[r] = 1'b1;
        exp_r1      = h;
        exp_r2      = l;
    endtask

    task automatic model(input logic s, input logic bv, input logic [7:0] b,
                         input logic e, input logic a);
        logic [7:0] ctrl;
        int d;
        exp_load = '0; exp_r1 = '0; exp_r2 = '0; exp_done = 1'b0; exp_err = 1'b0;
        if (a && m_active) begin
            exp_err  = 1'b1;
            m_active = 1'b0;
        end else if (s && !a) begin
            exp_err  = m_active;
            m_active = 1'b1;
            m_cnt    = 0;
            m_n      = 0;
`ifdef RECLOAD_CLEAR_EN
            exp_load = '1;
`endif
        end else if (e && m_active) begin
            if (frame_complete()) exp_done = 1'b1;
            else                  exp_err  = 1'b1;
            m_active = 1'b0;
        end else if (bv && m_active && !frame_complete()) begin
            fb[m_cnt] = b;
            m_cnt++;
            if (m_cnt == 2) begin
                expect_load(0, fb[0], fb[1]);
            end else if (m_cnt == 4) begin
                expect_load(1, fb[2], fb[3]);
                ctrl = fb[2];
                m_n  = (int'(ctrl[3:0]) > MAXDLC) ? MAXDLC : int'(ctrl[3:0]);
            end else if (m_cnt > 4) begin
                d = m_cnt - 4;
                if (d % 2 == 0)   expect_load(2 + (d - 2) / 2, fb[m_cnt-2], fb[m_cnt-1]);
                else if (d == m_n) expect_load(2 + (d - 1) / 2, b, 8'h00);
            end
        end
    endtask

    task automatic check(input string tag);
        logic [NREG+18:0] obs, exp;
        obs = {bus.reg_load, bus.regin1, bus.regin2, bus.rec_busy, bus.rec_done, bus.rec_err};
        exp = {exp_load, exp_r1, exp_r2, logic'(m_active), exp_done, exp_err};
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed load/hi/lo/busy/done/err=%h expected %h", tag, obs, exp);
    endtask

    task automatic step(input logic s, input logic bv, input logic [7:0] b,
                        input logic e, input logic a, input string tag);
        bus.sof = s; bus.byte_valid = bv; bus.byte_in = b; bus.eof = e; bus.abort = a;
        model(s, bv, b, e, a);
        @(posedge clk);
        #1;
        check(tag);
        bus.sof = 1'b0; bus.byte_valid = 1'b0; bus.byte_in = '0; bus.eof = 1'b0; bus.abort = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus.sof = 1'b0; bus.byte_valid = 1'b0; bus.byte_in = '0; bus.eof = 1'b0; bus.abort = 1'b0;
        m_active = 1'b0; m_cnt = 0; m_n = 0;
        exp_load = '0; exp_r1 = '0; exp_r2 = '0; exp_done = 1'b0; exp_err = 1'b0;
        @(posedge clk);
        #1;
        check(tag);
        rst = 1'b0;
    endtask

    task automatic send_fq(input string tag);
        foreach (fq[i]) step(1'b0, 1'b1, fq[i], 1'b0, 1'b0, tag);
    endtask

    initial begin
        do_reset("reset");
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "idle");

        // Full 8-byte frame
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "f8_sof");
        fq = '{8'h12, 8'h34, 8'h08, 8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3,
               8'hA4, 8'hA5, 8'hA6, 8'hA7};
        send_fq("f8_byte");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "f8_eof");
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "f8_after");

        // Odd DLC with zero pad
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "d3_sof");
        fq = '{8'h05, 8'h55, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
        send_fq("d3_byte");
        step(1'b0, 1'b1, 8'h44, 1'b0, 1'b0, "d3_extra");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "d3_eof");

        // DLC clamp
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "clamp_sof");
        fq = '{8'h7E, 8'h01, 8'h0F, 8'h00, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
               8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hFF};
        send_fq("clamp_byte");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "clamp_eof");

        // Abort after 5 bytes, then a normal frame
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "ab_sof");
        fq = '{8'h21, 8'h43, 8'h04, 8'h00, 8'hC0};
        send_fq("ab_byte");
        step(1'b0, 1'b1, 8'hC1, 1'b0, 1'b1, "ab_abort");
        step(1'b0, 1'b1, 8'hC2, 1'b0, 1'b0, "ab_ignored");
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "ab2_sof");
        fq = '{8'h65, 8'h87, 8'h02, 8'h00, 8'hD0, 8'hD1};
        send_fq("ab2_byte");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "ab2_eof");

        // sof mid-frame with a byte in the same cycle
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "rs_sof");
        fq = '{8'h11, 8'h22, 8'h01};
        send_fq("rs_byte");
        step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, "rs_restart");
        fq = '{8'hAB, 8'hCD, 8'h00, 8'h00};
        send_fq("rs_byte2");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "rs_eof");

        // abort+sof in idle, premature eof, eof in idle, reset mid-frame
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "idle_absof");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "idle_eof");
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "pe_sof");
        fq = '{8'h01, 8'h02, 8'h03};
        send_fq("pe_byte");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "pe_eof");
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "mr_sof");
        fq = '{8'h0A, 8'h0B};
        send_fq("mr_byte");
        do_reset("mr_reset");
        step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, "mr_after");

        // Random frames with gaps and occasional disruptions
        for (int f = 0; f < 40; f++) begin
            int nb;
            int ev;
            logic [7:0] dlc;
            dlc = 8'($urandom_range(0, 15));
            nb  = 4 + int'(dlc[3:0]) + int'($urandom_range(0, 2));
            step(1'b1, $urandom_range(0, 1) == 1, 8'($urandom), 1'b0, 1'b0, "rnd_sof");
            for (int i = 0; i < nb; i++) begin
                logic [7:0] b;
                b = (i == 2) ? {4'($urandom), dlc[3:0]} : 8'($urandom);
                for (int g = int'($urandom_range(0, 3)); g > 2; g--)
                    step(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, "rnd_gap");
                ev = int'($urandom_range(0, 99));
                if (ev < 2)      step(1'b0, 1'b1, b, 1'b0, 1'b1, "rnd_abort");
                else if (ev < 4) step(1'b1, 1'b1, b, 1'b0, 1'b0, "rnd_restart");
                else if (ev < 5) step(1'b0, 1'b1, b, 1'b1, 1'b0, "rnd_early_eof");
                else             step(1'b0, 1'b1, b, 1'b0, 1'b0, "rnd_byte");
            end
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "rnd_eof");
            step(1'b0, $urandom_range(0, 1) == 1, 8'($urandom), 1'b0, 1'b0, "rnd_idle");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
